// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI pixel prefetch path.
package hdmi_pkg;
  localparam int                PIX_W        = 16;
  localparam logic [PIX_W-1:0]  RGB565_BLACK = 16'h0000;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    FLUSH   = 2'd1,
    STREAM  = 2'd2
  } state_e;
endpackage

// File: rtl/pixel_fifo_core.sv
// Synchronous FIFO: wrapping pointers, level with an extra bit so full and
// empty are distinct, and a synchronous clear that beats push/pop.
module pixel_fifo_core #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [AW:0]       level_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              push_ok, pop_ok;

  // Guard against overrun/underrun locally so the core is safe on its own.
  assign push_ok = push_i && !clr_i && (level_q != (AW+1)'(DEPTH));
  assign pop_ok  = pop_i  && !clr_i && (level_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Next pointers/level; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/hdmi_pixel_prefetch.sv
// Pixel prefetch buffer in front of the HDMI top: vsync-driven frame flush,
// 1-cycle-latency pixel delivery and underflow statistics.
module hdmi_pixel_prefetch
  import hdmi_pkg::*;
#(
  parameter int                DATA_W          = PIX_W,
  parameter int                DEPTH           = 32,
  parameter logic              VS_ACTIVE       = 1'b1,
  parameter logic [DATA_W-1:0] UNDERFLOW_COLOR = RGB565_BLACK
) (
  input  logic                   pixel_clk,
  input  logic                   sys_rst,
  input  logic                   video_vs,
  input  logic                   data_req,
  output logic [DATA_W-1:0]      data_out,
  input  logic                   src_valid,
  input  logic [DATA_W-1:0]      src_data,
  output logic                   src_ready,
  output logic                   frame_start,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            underflow_cnt,
  output logic                   underflow_sticky
);
  localparam int AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic              vs_d_q;
  logic              vs_edge;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [15:0]       ucnt_q, ucnt_d;
  logic              sticky_q, sticky_d;
  logic [DATA_W-1:0] head;
  logic [AW:0]       level;
  logic              flush_clr, push, pop, uflow, req_live, fifo_empty;

  assign vs_edge    = (video_vs == VS_ACTIVE) && (vs_d_q != VS_ACTIVE);
  // FLUSH is a fixed one-cycle state; an edge seen there does not re-clear.
  assign flush_clr  = vs_edge && (state_q != FLUSH);
  assign fifo_empty = (level == '0);
  assign req_live   = data_req && !flush_clr;
  assign push       = src_valid && src_ready && !flush_clr;
  assign pop        = req_live && (state_q == STREAM) && !fifo_empty;
  assign uflow      = req_live && (state_q == STREAM) && fifo_empty;

  pixel_fifo_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (pixel_clk),
    .rst_i   (sys_rst),
    .clr_i   (flush_clr),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (src_data),
    .rdata_o (head),
    .level_o (level)
  );

  // Frame FSM next state and decoded handshake outputs.
  always_comb begin
    state_d     = state_q;
    src_ready   = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      WAIT_VS: if (vs_edge) state_d = FLUSH;
      FLUSH: begin
        frame_start = 1'b1;
        state_d     = STREAM;
      end
      STREAM: begin
        // Depends only on level: a pop at full does not open a push slot.
        src_ready = (level < (AW+1)'(DEPTH));
        if (vs_edge) state_d = FLUSH;
      end
      default: state_d = WAIT_VS;
    endcase
  end

  // Pixel output and underflow statistics next state.
  always_comb begin
    data_out_d = data_out_q;
    ucnt_d     = ucnt_q;
    sticky_d   = sticky_q | uflow;
    if (req_live) data_out_d = pop ? head : UNDERFLOW_COLOR;
    if (uflow && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  // State, vsync history and output registers.
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= WAIT_VS;
      vs_d_q     <= ~VS_ACTIVE;
      data_out_q <= '0;
      ucnt_q     <= '0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_d_q     <= video_vs;
      data_out_q <= data_out_d;
      ucnt_q     <= ucnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign data_out         = data_out_q;
  assign fifo_level       = level;
  assign underflow_cnt    = ucnt_q;
  assign underflow_sticky = sticky_q;
endmodule

// File: tb/tb_hdmi_pixel_prefetch.sv
// Self-checking bench for hdmi_pixel_prefetch against a queue-based model.
module tb_hdmi_pixel_prefetch;
  localparam int          DEPTH = 32;
  localparam logic [15:0] UC    = 16'hF800;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        video_vs = 1'b0, data_req = 1'b0, src_valid = 1'b0;
  logic [15:0] src_data = '0;
  logic [15:0] data_out;
  logic        src_ready, frame_start, underflow_sticky;
  logic [5:0]  fifo_level;
  logic [15:0] underflow_cnt;

  int n_checks = 0, n_err = 0;

  hdmi_pixel_prefetch #(.DATA_W(16), .DEPTH(DEPTH), .VS_ACTIVE(1'b1),
                        .UNDERFLOW_COLOR(UC)) dut (
    .pixel_clk(clk), .sys_rst(sys_rst), .video_vs(video_vs),
    .data_req(data_req), .data_out(data_out), .src_valid(src_valid),
    .src_data(src_data), .src_ready(src_ready), .frame_start(frame_start),
    .fifo_level(fifo_level), .underflow_cnt(underflow_cnt),
    .underflow_sticky(underflow_sticky)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = waiting for vsync, 1 = flush cycle, 2 = streaming.
  int          m_ph;
  logic [15:0] q[$];
  bit          m_vsd;
  logic [15:0] m_dout;
  int          m_cnt;
  bit          m_sticky;
  bit          a_ready, a_fs, e_ready, e_fs;

  task automatic model_reset();
    m_ph = 0; q.delete(); m_vsd = 0; m_dout = 16'h0; m_cnt = 0; m_sticky = 0;
  endtask

  task automatic model_step(input bit rdy);
    bit vedge;
    vedge = video_vs && !m_vsd;
    m_vsd = video_vs;
    case (m_ph)
      0: if (vedge) begin q.delete(); m_ph = 1; end
         else if (data_req) m_dout = UC;
      1: begin if (data_req) m_dout = UC; m_ph = 2; end
      default:
        if (vedge) begin q.delete(); m_ph = 1; end
        else begin
          if (data_req) begin
            if (q.size() > 0) m_dout = q.pop_front();
            else begin
              m_dout = UC; m_sticky = 1;
              if (m_cnt < 65535) m_cnt++;
            end
          end
          if (src_valid && rdy) q.push_back(src_data);
        end
    endcase
  endtask

  // One clock: sample combinational outputs mid-cycle, advance model at the edge.
  task automatic tick();
    @(negedge clk);
    a_ready = src_ready; a_fs = frame_start;
    e_ready = (m_ph == 2) && (q.size() < DEPTH);
    e_fs    = (m_ph == 1);
    @(posedge clk);
    model_step(e_ready);
    #1;
  endtask

  task automatic start_frame();
    video_vs = 1; tick();
    video_vs = 0; tick();
  endtask

  task automatic push_n(input int n, input logic [15:0] base);
    src_valid = 1;
    for (int i = 0; i < n; i++) begin src_data = base + 16'(i); tick(); end
    src_valid = 0;
  endtask

  task automatic test_reset();
    sys_rst = 1; video_vs = 0; data_req = 0; src_valid = 0;
    repeat (3) @(posedge clk);
    #1; model_reset();
    n_checks++; if (data_out !== 16'h0) begin n_err++; $display("FAIL rst_dout got %h want 0000", data_out); end
    n_checks++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", src_ready); end
    n_checks++; if (fifo_level !== 6'd0) begin n_err++; $display("FAIL rst_level got %0d want 0", fifo_level); end
    n_checks++; if (underflow_cnt !== 16'h0 || underflow_sticky !== 1'b0) begin n_err++; $display("FAIL rst_uflow got %h/%b want 0/0", underflow_cnt, underflow_sticky); end
    n_checks++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL rst_fs got %b want 0", frame_start); end
    @(negedge clk); sys_rst = 0;
    data_req = 1; tick(); data_req = 0;
    n_checks++; if (a_ready !== 1'b0 || data_out !== UC || underflow_cnt !== 16'h0) begin n_err++; $display("FAIL wait_req got rdy=%b dout=%h cnt=%h want 0/%h/0", a_ready, data_out, underflow_cnt, UC); end
  endtask

  task automatic test_frame_start();
    video_vs = 1; tick();
    n_checks++; if (a_fs !== 1'b0) begin n_err++; $display("FAIL fs_early got %b want 0", a_fs); end
    tick();
    n_checks++; if (a_fs !== 1'b1 || a_ready !== 1'b0) begin n_err++; $display("FAIL fs_pulse got fs=%b rdy=%b want 1/0", a_fs, a_ready); end
    tick();
    n_checks++; if (a_fs !== 1'b0 || a_ready !== 1'b1) begin n_err++; $display("FAIL fs_stream got fs=%b rdy=%b want 0/1", a_fs, a_ready); end
    video_vs = 0;
    src_valid = 1;
    for (int i = 1; i <= 32; i++) begin
      src_data = 16'(i); tick();
      n_checks++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready i=%0d got %b want 1", i, a_ready); end
    end
    src_valid = 0;
    n_checks++; if (fifo_level !== 6'd32 || src_ready !== 1'b0) begin n_err++; $display("FAIL full got lvl=%0d rdy=%b want 32/0", fifo_level, src_ready); end
  endtask

  task automatic test_full_pop();
    data_req = 1; src_valid = 1; src_data = 16'h0021; tick();
    n_checks++; if (a_ready !== 1'b0 || data_out !== 16'h0001 || fifo_level !== 6'd31) begin n_err++; $display("FAIL full_pop1 got rdy=%b dout=%h lvl=%0d want 0/0001/31", a_ready, data_out, fifo_level); end
    src_valid = 0; tick();
    n_checks++; if (data_out !== 16'h0002) begin n_err++; $display("FAIL full_pop2 got %h want 0002", data_out); end
    tick();
    n_checks++; if (data_out !== 16'h0003 || fifo_level !== 6'd29) begin n_err++; $display("FAIL full_pop3 got dout=%h lvl=%0d want 0003/29", data_out, fifo_level); end
    data_req = 0; src_valid = 1; src_data = 16'h0021; tick(); src_valid = 0;
    n_checks++; if (a_ready !== 1'b1 || fifo_level !== 6'd30 || data_out !== 16'h0003) begin n_err++; $display("FAIL resume got rdy=%b lvl=%0d dout=%h want 1/30/0003", a_ready, fifo_level, data_out); end
  endtask

  task automatic test_underflow();
    data_req = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_checks++; if (data_out !== m_dout) begin n_err++; $display("FAIL drain i=%0d got %h want %h", i, data_out, m_dout); end
    end
    n_checks++; if (data_out !== 16'h0021) begin n_err++; $display("FAIL drain_last got %h want 0021", data_out); end
    tick(); tick(); data_req = 0;
    n_checks++; if (data_out !== UC || underflow_cnt !== 16'd2 || underflow_sticky !== 1'b1) begin n_err++; $display("FAIL uflow got dout=%h cnt=%0d st=%b want %h/2/1", data_out, underflow_cnt, underflow_sticky, UC); end
  endtask

  task automatic test_reset_midrun();
    start_frame(); push_n(12, 16'h0100);
    n_checks++; if (fifo_level !== 6'd12) begin n_err++; $display("FAIL pre_rst_lvl got %0d want 12", fifo_level); end
    #2 sys_rst = 1;
    #1;
    n_checks++; if (data_out !== 16'h0 || src_ready !== 1'b0 || fifo_level !== 6'd0 || underflow_cnt !== 16'h0 || underflow_sticky !== 1'b0) begin n_err++; $display("FAIL midrst got dout=%h rdy=%b lvl=%0d cnt=%h st=%b want 0/0/0/0/0", data_out, src_ready, fifo_level, underflow_cnt, underflow_sticky); end
    model_reset();
    @(negedge clk); sys_rst = 0;
    data_req = 1; tick(); tick(); data_req = 0;
    n_checks++; if (a_ready !== 1'b0 || data_out !== UC || underflow_cnt !== 16'h0 || underflow_sticky !== 1'b0) begin n_err++; $display("FAIL wait_uflow got rdy=%b dout=%h cnt=%h st=%b want 0/%h/0/0", a_ready, data_out, underflow_cnt, underflow_sticky, UC); end
  endtask

  task automatic test_vs_flush();
    start_frame(); push_n(10, 16'h0200);
    n_checks++; if (fifo_level !== 6'd10) begin n_err++; $display("FAIL pre_vs_lvl got %0d want 10", fifo_level); end
    video_vs = 1; data_req = 1; src_valid = 1; src_data = 16'h0BAD; tick();
    n_checks++; if (fifo_level !== 6'd0 || underflow_cnt !== 16'h0 || data_out !== m_dout) begin n_err++; $display("FAIL vs_clear got lvl=%0d cnt=%h dout=%h want 0/0/%h", fifo_level, underflow_cnt, data_out, m_dout); end
    video_vs = 0; data_req = 0; src_valid = 0; tick();
    n_checks++; if (a_fs !== 1'b1) begin n_err++; $display("FAIL vs_fs got %b want 1", a_fs); end
    src_valid = 1; src_data = 16'h00AA; tick(); src_valid = 0;
    data_req = 1; tick(); data_req = 0;
    n_checks++; if (data_out !== 16'h00AA || underflow_cnt !== 16'h0) begin n_err++; $display("FAIL vs_next got dout=%h cnt=%h want 00aa/0", data_out, underflow_cnt); end
  endtask

  task automatic test_random();
    int vs_hold, p_push, p_pop;
    vs_hold = 0; p_push = 60; p_pop = 50;
    for (int c = 0; c < 2500; c++) begin
      if (c % 200 == 0) begin p_push = $urandom_range(10, 90); p_pop = $urandom_range(10, 90); end
      if (vs_hold > 0) vs_hold--;
      else if ($urandom_range(0, 299) == 0) vs_hold = 3;
      video_vs  = (vs_hold > 0);
      src_valid = ($urandom_range(0, 99) < p_push);
      data_req  = ($urandom_range(0, 99) < p_pop);
      src_data  = 16'($urandom);
      tick();
      n_checks++;
      if (data_out !== m_dout || fifo_level !== 6'(q.size()) || a_ready !== e_ready ||
          a_fs !== e_fs || underflow_cnt !== 16'(m_cnt) || underflow_sticky !== m_sticky) begin
        n_err++;
        $display("FAIL rand c=%0d got dout=%h lvl=%0d rdy=%b fs=%b cnt=%0d st=%b want %h/%0d/%b/%b/%0d/%b",
                 c, data_out, fifo_level, a_ready, a_fs, underflow_cnt, underflow_sticky,
                 m_dout, q.size(), e_ready, e_fs, m_cnt, m_sticky);
      end
    end
    video_vs = 0; src_valid = 0; data_req = 0;
  endtask

  task automatic test_saturation();
    sys_rst = 1; #3; model_reset();
    @(negedge clk); sys_rst = 0;
    start_frame();
    data_req = 1;
    repeat (65534) tick();
    n_checks++; if (underflow_cnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_pre got %h want fffe", underflow_cnt); end
    tick();
    n_checks++; if (underflow_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hit got %h want ffff", underflow_cnt); end
    tick(); tick(); data_req = 0;
    n_checks++; if (underflow_cnt !== 16'hFFFF || underflow_sticky !== 1'b1 || data_out !== UC) begin n_err++; $display("FAIL sat_hold got cnt=%h st=%b dout=%h want ffff/1/%h", underflow_cnt, underflow_sticky, data_out, UC); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_frame_start();
    test_full_pop();
    test_underflow();
    test_reset_midrun();
    test_vs_flush();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/hdmi_pixel_prefetch.md
Name: hdmi_pixel_prefetch

Overview:
Pixel prefetch buffer that sits directly upstream of the HDMI output top. It accepts RGB565 pixels from a frame-buffer read source over a valid/ready handshake and stores them in a small FIFO. It answers the video driver's data_req with a 1-cycle-latency pixel on data_out, which drives the HDMI top's data_in. At every frame start (vsync active edge) it flushes the FIFO and pulses frame_start so the source can restart its read address.

Parameters:
DATA_W, 16, pixel width (RGB565)
DEPTH, 32, FIFO entries; must be a power of 2, minimum 4
VS_ACTIVE, 1'b1, video_vs level that marks the vsync pulse
UNDERFLOW_COLOR, 16'h0000, pixel driven when data_req arrives with an empty FIFO

Ports:
pixel_clk  in  1  pixel clock; the only clock
sys_rst  in  1  asynchronous, active-high reset
video_vs  in  1  vsync from the HDMI top
data_req  in  1  pixel request from the HDMI top; one pop per cycle high
data_out  out  DATA_W  pixel to the HDMI top data_in; valid the cycle after data_req
src_valid  in  1  source pixel valid
src_data  in  DATA_W  source pixel
src_ready  out  1  FIFO accepts src_data this cycle
frame_start  out  1  single-cycle pulse at each frame flush
fifo_level  out  $clog2(DEPTH)+1  current occupancy
underflow_cnt  out  16  saturating count of underflow pops
underflow_sticky  out  1  set on any underflow; cleared only by reset

Behaviour:
- Reset (async assert, sync release):
  - state=WAIT_VS, pointers 0, fifo_level=0
  - data_out=0, src_ready=0, frame_start=0
  - underflow_cnt=0, underflow_sticky=0
  - vs_d=~VS_ACTIVE, so a vsync already active when reset releases counts as an edge.
- Edge detect: vs_d registers video_vs. vs_edge = (video_vs==VS_ACTIVE) && (vs_d!=VS_ACTIVE), combinational.
- FSM states: WAIT_VS, FLUSH, STREAM.
  - WAIT_VS: src_ready=0. data_req returns UNDERFLOW_COLOR without counting. vs_edge -> FLUSH.
  - FLUSH: lasts exactly 1 cycle. frame_start=1, src_ready=0. Next state is STREAM.
  - STREAM: src_ready = (fifo_level<DEPTH). vs_edge -> FLUSH.
- On any cycle with vs_edge, from WAIT_VS or STREAM:
  - pointers and level clear at that clock edge; all buffered data is discarded.
  - A push or pop in the same cycle is ignored; no count, no data.
- Push: occurs on src_valid && src_ready. src_ready is combinational from the state and the current level, with no dependence on data_req. At full, a simultaneous pop does not enable a push that cycle.
- Pop, in STREAM only, when data_req=1:
  - Level > 0: the head entry is registered onto data_out on the next edge (latency 1).
  - Level = 0: data_out<=UNDERFLOW_COLOR, underflow_cnt+1 (saturates at 16'hFFFF), sticky<=1.
  - No bypass: a push arriving in an empty cycle is not visible to a pop in that same cycle.
- Simultaneous push and pop with 0<level<DEPTH: level is unchanged and both take effect.
- data_out holds its last value when data_req=0.
- In FLUSH, data_req returns UNDERFLOW_COLOR and is not counted.
- Pointers wrap modulo DEPTH. The level uses one extra bit so full and empty are distinct.
- No frame-length checking; the source is responsible for supplying the correct pixel count.

Decomposition:
- hdmi_pkg:
  - PIX_W=16
  - RGB565_BLACK=16'h0000
  - state enum {WAIT_VS, FLUSH, STREAM}
- Sub-module pixel_fifo_core (sync FIFO: memory, wrapping pointers, level, sync clear) holds the storage.
- The top holds the FSM, vsync edge detect, data_out register and underflow statistics.

Test Plan:
1. Assert sys_rst mid-run with level=12 -> immediately data_out=0, src_ready=0, fifo_level=0, underflow_cnt=0; after release, state WAIT_VS.
2. Raise video_vs at cycle N -> frame_start=1 only at cycle N+1; src_ready=1 from N+2. Push 0x0001..0x0020 back-to-back -> src_ready=0 after the 32nd push, fifo_level=32.
3. Full FIFO, data_req high 3 cycles -> data_out=0x0001, 0x0002, 0x0003 on the cycles following each req; level=29; src_valid held high -> no push while full, push resumes next cycle.
4. UNDERFLOW_COLOR=16'hF800, empty FIFO in STREAM, data_req 2 cycles -> data_out=16'hF800, underflow_cnt=2, sticky=1. The same in WAIT_VS -> count unchanged.
5. Level=10, vsync edge coinciding with data_req and src_valid -> level=0, no pop or count, frame_start pulse; the next pushed 0x00AA is the next popped pixel.
6. Preload underflow_cnt near saturation (force 16'hFFFE), 3 underflow pops -> count stays 16'hFFFF.
